// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit, one result bit per clock.
//
// Operations (op_i): 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
// Multiply uses shift-add. Divide uses restoring shift-subtract.
// Signed operations work on magnitudes, and the signs are applied when the
// result is written.
//
// Ports:
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous reset, active low
//   start_i    request a new operation (sampled only in IDLE)
//   op_i       operation select
//   opdata1_i  multiplicand / dividend
//   opdata2_i  multiplier / divisor
//   annul_i    cancel an in-flight operation
//   busy_o     stall request, high in ZERO and CALC
//   ready_o    one-cycle pulse; hi_o/lo_o hold a new result
//   hi_o       product upper half, or remainder
//   lo_o       product lower half, or quotient
//
// state | meaning
// IDLE  | waiting for start_i
// ZERO  | divide by zero; result is written on the next edge
// CALC  | one bit per edge, W edges in total
// DONE  | result valid, ready_o high for this single cycle
module ex_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [W-1:0] opdata1_i,
  input  logic [W-1:0] opdata2_i,
  input  logic         annul_i,
  output logic         busy_o,
  output logic         ready_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          op_div;
  logic          neg_res;   // negate product / quotient
  logic          neg_rem;   // negate remainder (dividend was negative)
  // For multiply this holds the multiplicand magnitude.
  // For divide it holds the divisor magnitude.
  // For divide by zero it holds the raw dividend.
  logic [W-1:0]  opnd;
  logic [W-1:0]  acc_hi;    // partial product high half / running remainder
  logic [W-1:0]  acc_lo;    // multiplier bits / dividend bits -> quotient
  logic [W-1:0]  hi_r, lo_r;

  // decode of the request in IDLE
  logic         in_signed, in_div, in_div0, accept;
  logic         sign1, sign2;
  logic [W-1:0] mag1, mag2;

  always_comb begin
    in_signed = ~op_i[0];
    in_div    = op_i[1];
    in_div0   = in_div && (opdata2_i == '0);
    accept    = (state == IDLE) && start_i && !annul_i;
    sign1     = in_signed & opdata1_i[W-1];
    sign2     = in_signed & opdata2_i[W-1];
    mag1      = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
    mag2      = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  // one iteration step
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift, div_diff;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};
    step_hi   = '0;
    step_lo   = '0;
    if (op_div) begin
      // The top bit of the difference set means it went negative, so the
      // partial remainder is restored.
      if (!div_diff[W]) begin
        step_hi = div_diff[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end
  end

  // Sign fix applied to the last step, on the edge into DONE.
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    quo_fix  = neg_res ? (~step_lo + 1'b1) : step_lo;
    rem_fix  = neg_rem ? (~step_hi + 1'b1) : step_hi;
    if (op_div) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*W-1:W];
      res_lo = prod_fix[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    ready_o   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = in_div0 ? ZERO : CALC;
      end
      ZERO: begin
        busy_o    = 1'b1;
        state_nxt = annul_i ? IDLE : DONE;
      end
      CALC: begin
        busy_o = 1'b1;
        if (annul_i)          state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = DONE;
      end
      DONE: begin
        ready_o   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= CNT_LOAD;
            op_div  <= in_div;
            neg_res <= sign1 ^ sign2;
            neg_rem <= sign1;
            acc_hi  <= '0;
            if (in_div0) begin
              opnd   <= opdata1_i;
              acc_lo <= '0;
            end else if (in_div) begin
              opnd   <= mag2;
              acc_lo <= mag1;
            end else begin
              opnd   <= mag1;
              acc_lo <= mag2;
            end
          end
        end
        ZERO: begin
          if (!annul_i) begin
            hi_r <= opnd;
            lo_r <= '1;
          end
        end
        CALC: begin
          if (!annul_i) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              hi_r <= res_hi;
              lo_r <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv with W=32.
module tb_ex_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] opdata1_i, opdata2_i;
  logic         annul_i;
  logic         busy_o, ready_o;
  logic [W-1:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  ex_muldiv #(.W(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues the request, counts edges from the accept
  // edge (edge 1) until ready_o is seen, then checks the result and the
  // pulse width. Returns at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input int exp_busy,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n;
    int nbusy;
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    nbusy = 0;
    while (!ready_o && n < 100) begin
      if (busy_o) nbusy++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(nbusy), 64'(exp_busy));
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    @(negedge clk);
    chk({tag, "_pulse"}, {62'b0, ready_o, busy_o}, 64'b0);
  endtask

  initial begin
    int rdy_cnt;
    rst = 1'b0; start_i = 1'b0; op_i = MULT; opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", {busy_o, ready_o, hi_o, lo_o}, 66'b0);
    rst = 1'b1;
    @(negedge clk);

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m3x5", MULT, 32'hFFFFFFFD, 32'd5, 33, 32, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_m7d2", DIV, 32'hFFFFFFF9, 32'd2, 33, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_5d0", DIVU, 32'd5, 32'd0, 2, 1, 32'h00000005, 32'hFFFFFFFF);
    run_op("div_7dm2", DIV, 32'd7, 32'hFFFFFFFE, 33, 32, 32'h00000001, 32'hFFFFFFFD);
    run_op("mult_m1xm1", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32, 32'h0, 32'h1);
    run_op("div_m5d0", DIV, 32'hFFFFFFFB, 32'd0, 2, 1, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("multu_carry", MULTU, 32'h00010000, 32'h00010000, 33, 32, 32'h1, 32'h0);
    run_op("div_min", DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32, 32'h00000000, 32'h80000000);

    // annul during CALC with start_i pulses that must be ignored
    start_i = 1'b1; op_i = MULTU; opdata1_i = 32'd123; opdata2_i = 32'd456;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      start_i = i[0];
      @(negedge clk);
    end
    start_i = 1'b0;
    chk("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy_after", 64'(busy_o), 64'd0);
    chk("annul_hold", {hi_o, lo_o}, {32'h00000000, 32'h80000000});
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || busy_o) rdy_cnt++;
      @(negedge clk);
    end
    chk("annul_no_ready", 64'(rdy_cnt), 64'd0);

    run_op("divu_100d7", DIVU, 32'd100, 32'd7, 33, 32, 32'd2, 32'd14);

    // reset mid-CALC
    start_i = 1'b1; op_i = MULTU; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mid_out", {busy_o, ready_o, hi_o, lo_o}, 66'b0);
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || busy_o) rdy_cnt++;
      @(negedge clk);
    end
    chk("rst_mid_no_ready", 64'(rdy_cnt), 64'd0);

    // no accept while in reset
    rst = 1'b0; start_i = 1'b1; op_i = DIVU; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    chk("rst_start_ignored", {62'b0, busy_o, ready_o}, 64'b0);
    @(negedge clk);
    chk("rst_start_idle", {62'b0, busy_o, ready_o}, 64'b0);

    // annul wins over start in IDLE
    start_i = 1'b1; annul_i = 1'b1; op_i = DIVU; opdata1_i = 32'd9; opdata2_i = 32'd0;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    chk("idle_annul_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    chk("idle_annul_ready", {62'b0, ready_o, busy_o}, 64'b0);

    run_op("multu_after", MULTU, 32'd6, 32'd7, 33, 32, 32'd0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result width; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port start_i  input  1  request new operation; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port opdata1_i  input  W  multiplicand / dividend.
REQ-007 SHALL have port opdata2_i  input  W  multiplier / divisor.
REQ-008 SHALL have port annul_i  input  1  cancel an in-flight operation (branch flush / exception).
REQ-009 SHALL have port busy_o  output  1  stall request to pipeline; high in ZERO and CALC.
REQ-010 SHALL have port ready_o  output  1  one-cycle pulse; hi_o/lo_o valid.
REQ-011 SHALL have port hi_o  output  W  HI result: product upper half, or remainder.
REQ-012 SHALL have port lo_o  output  W  LO result: product lower half, or quotient.

Function
REQ-013 SHALL implement FSM states IDLE, ZERO, CALC, DONE; busy_o = (ZERO or CALC); ready_o = DONE.
REQ-014 SHALL, in IDLE, with start_i=1 and annul_i=0, capture op_i and operands at the edge; annul_i=1 wins and nothing is accepted.
REQ-015 SHALL go IDLE->ZERO on accept when op is DIV/DIVU and opdata2_i=0; otherwise IDLE->CALC with bit counter cleared.
REQ-016 SHALL, for signed ops (MULT, DIV), convert operands to magnitudes at accept and record sign of each; unsigned ops use operands as-is.
REQ-017 SHALL process exactly one bit per CALC edge (shift-add for multiply, restoring shift-subtract for divide); after W CALC edges go to DONE.
REQ-018 SHALL apply sign fix on entry to DONE: product and quotient negated if operand signs differ; remainder takes dividend sign.
REQ-019 SHALL yield, for DIV of -2^(W-1) by -1, quotient -2^(W-1) (wrap) and remainder 0, with no error indication.
REQ-020 SHALL go ZERO->DONE on next edge, with divide-by-zero result hi_o = dividend, lo_o = all ones.
REQ-021 SHALL hold ready_o high for exactly one cycle in DONE, then return to IDLE on the next edge unconditionally.
REQ-022 SHALL give latency of W+1 edges from accept to ready_o for normal ops, and 2 edges for divide-by-zero.
REQ-023 SHALL update hi_o/lo_o only on entry to DONE and hold them until the next DONE entry.
REQ-024 SHALL ignore start_i in ZERO, CALC and DONE; no queueing.
REQ-025 SHALL, on annul_i=1 in ZERO or CALC, return to IDLE next edge, with no ready_o and hi_o/lo_o unchanged.
REQ-026 SHALL treat annul_i in DONE and IDLE as having no effect on outputs.
REQ-027 SHALL, when an operation is accepted in the cycle following DONE (i.e. in IDLE), behave identically to one accepted from a long-idle state.

Reset
REQ-028 SHALL, with rst=0 at an edge, set state IDLE, clear counter and all internal registers, and drive busy_o=0, ready_o=0, hi_o=0, lo_o=0.
REQ-029 SHALL, on reset asserted mid-operation (ZERO/CALC/DONE), abort with no ready_o pulse; the result is lost.
REQ-030 SHALL accept no operation in a cycle where rst=0, regardless of start_i.

Verification (W=32)
REQ-031 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> ready_o exactly 33 edges after accept, hi_o=0xFFFFFFFE, lo_o=0x00000001, busy_o high for 32 cycles.
REQ-032 SHALL cover MULT -3 x 5, then DIV -7 / 2 back-to-back -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-033 SHALL cover DIVU 5 / 0 -> ready_o 2 edges after accept, hi_o=0x00000005, lo_o=0xFFFFFFFF.
REQ-034 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0x00000000.
REQ-035 SHALL cover annul_i at CALC edge 10 -> busy_o low next cycle, no ready_o, prior hi_o/lo_o retained; start_i pulses during CALC ignored; next DIVU 100 / 7 gives lo_o=14, hi_o=2.
REQ-036 SHALL cover rst=0 at CALC edge 20 -> all outputs 0 next cycle, state IDLE, no ready_o pulse afterwards.
